// File: rtl/bin2bcd_param.sv
// bin2bcd_param
// Sequential binary-to-BCD converter using the shift-add-3 (double-dabble)
// method. It processes one input bit per clock. The input width, the digit
// count and the signedness of the input are set by parameters.
//
// Parameters:
//   BIN_W  : binary input width in bits (2..32)
//   DIGITS : number of BCD output digits (1..10)
//   SIGNED : 1 = bin_i is two's complement, 0 = unsigned
//
// Ports:
//   clk_i       : system clock, rising edge
//   reset_i     : asynchronous active-high reset; aborts a running conversion
//   start_i     : conversion request, sampled only while ready_o=1
//   bin_i       : binary operand, sampled together with start_i
//   ready_o     : high while idle and able to accept start_i
//   done_tick_o : one-cycle pulse; result outputs are valid from this cycle
//   bcd_o       : packed BCD result, digit 0 (units) in bits [3:0]
//   neg_o       : the input was negative (always 0 when SIGNED=0)
//   overflow_o  : magnitude exceeded 10^DIGITS-1; bcd_o saturates to all 9s
//   blank_o     : bit i=1 means digit i is a leading zero; bit 0 is always 0
module bin2bcd_param #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4,
  parameter int SIGNED = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  ready_o,
  output logic                  done_tick_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  neg_o,
  output logic                  overflow_o,
  output logic [DIGITS-1:0]     blank_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  // Reset value of the blank mask: every digit except the units is blanked.
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP   = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   mag_q;
  logic [BCD_W-1:0]   work_q;
  logic               ovf_acc_q;
  logic               neg_acc_q;

  logic [BCD_W-1:0]   bcd_q;
  logic               neg_q;
  logic               ovf_q;
  logic [DIGITS-1:0]  blank_q;

  logic               neg_in;
  logic [BIN_W-1:0]   mag_in;
  logic [BCD_W-1:0]   adj_work;
  logic [BCD_W-1:0]   work_d;
  logic [BIN_W-1:0]   mag_d;
  logic               ovf_acc_d;
  logic [BCD_W-1:0]   sat_bcd;
  logic [DIGITS-1:0]  blank_d;
  logic               last_step;

  // Operand conditioning. The negation is kept at BIN_W bits as an unsigned
  // number, so the most negative input maps onto its exact magnitude.
  assign neg_in = (SIGNED != 0) && bin_i[BIN_W-1];
  assign mag_in = neg_in ? (~bin_i + BIN_W'(1)) : bin_i;

  // Add-3 correction, applied to each work digit before the shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign adj_work[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5) ?
                                 (work_q[4*gi +: 4] + 4'd3) :
                                  work_q[4*gi +: 4];
  end

  // One shift of {work, magnitude}. Any bit that leaves the top of the work
  // register means the value needs more digits than are available.
  assign work_d    = {adj_work[BCD_W-2:0], mag_q[BIN_W-1]};
  assign mag_d     = {mag_q[BIN_W-2:0], 1'b0};
  assign ovf_acc_d = ovf_acc_q | adj_work[BCD_W-1];
  assign last_step = (cnt_q == CNT_W'(1));

  // Final result as it will be presented after the last shift.
  assign sat_bcd = ovf_acc_d ? {DIGITS{4'h9}} : work_d;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
    if (gi == 0) begin : g_units
      assign blank_d[gi] = 1'b0;
    end else begin : g_upper
      assign blank_d[gi] = (sat_bcd[BCD_W-1:4*gi] == '0);
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d     = state_q;
    ready_o     = 1'b0;
    done_tick_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          state_d = ST_OP;
        end
      end
      ST_OP: begin
        if (last_step) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_tick_o = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath. The result registers load only on the final shift, so the
  // display keeps the previous result while a conversion is running.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      mag_q     <= '0;
      work_q    <= '0;
      ovf_acc_q <= 1'b0;
      neg_acc_q <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      blank_q   <= BLANK_RST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mag_q     <= mag_in;
            neg_acc_q <= neg_in;
            work_q    <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= CNT_W'(BIN_W);
          end
        end
        ST_OP: begin
          work_q    <= work_d;
          mag_q     <= mag_d;
          ovf_acc_q <= ovf_acc_d;
          cnt_q     <= cnt_q - CNT_W'(1);
          if (last_step) begin
            bcd_q   <= sat_bcd;
            neg_q   <= neg_acc_q;
            ovf_q   <= ovf_acc_d;
            blank_q <= blank_d;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bcd_o      = bcd_q;
  assign neg_o      = neg_q;
  assign overflow_o = ovf_q;
  assign blank_o    = blank_q;

endmodule

// File: tb/tb_bin2bcd_param.sv
// Testbench for bin2bcd_param. Three instances share the clock, the reset
// and the operand: the default configuration, a 3-digit one and a signed
// one. Every result is compared against a plain-arithmetic decimal model.
module tb_bin2bcd_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] bin;

  logic        ready_def, done_def, neg_def, ovf_def;
  logic [15:0] bcd_def;
  logic [3:0]  blank_def;

  logic        ready_d3, done_d3, neg_d3, ovf_d3;
  logic [11:0] bcd_d3;
  logic [2:0]  blank_d3;

  logic        ready_sg, done_sg, neg_sg, ovf_sg;
  logic [15:0] bcd_sg;
  logic [3:0]  blank_sg;

  int checks = 0;
  int errors = 0;

  logic [15:0] prev_def, prev_d3, prev_sg;
  bit          held_ok;

  always #5 clk = ~clk;

  bin2bcd_param #(.BIN_W(12), .DIGITS(4), .SIGNED(0)) u_def (
    .clk_i(clk), .reset_i(rst), .start_i(start), .bin_i(bin),
    .ready_o(ready_def), .done_tick_o(done_def), .bcd_o(bcd_def),
    .neg_o(neg_def), .overflow_o(ovf_def), .blank_o(blank_def)
  );

  bin2bcd_param #(.BIN_W(12), .DIGITS(3), .SIGNED(0)) u_d3 (
    .clk_i(clk), .reset_i(rst), .start_i(start), .bin_i(bin),
    .ready_o(ready_d3), .done_tick_o(done_d3), .bcd_o(bcd_d3),
    .neg_o(neg_d3), .overflow_o(ovf_d3), .blank_o(blank_d3)
  );

  bin2bcd_param #(.BIN_W(12), .DIGITS(4), .SIGNED(1)) u_sg (
    .clk_i(clk), .reset_i(rst), .start_i(start), .bin_i(bin),
    .ready_o(ready_sg), .done_tick_o(done_sg), .bcd_o(bcd_sg),
    .neg_o(neg_sg), .overflow_o(ovf_sg), .blank_o(blank_sg)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: magnitude, saturation and digit extraction done with
  // ordinary integer arithmetic.
  task automatic model(input logic [11:0] b, input int digs, input bit sgn,
                       output logic [63:0] ebcd, output logic eneg,
                       output logic eovf, output logic [63:0] eblank);
    longint mag, lim, v, p;
    eneg = sgn && b[11];
    mag  = longint'(b);
    if (eneg) mag = 4096 - mag;
    lim = 1;
    for (int i = 0; i < digs; i++) lim = lim * 10;
    lim  = lim - 1;
    eovf = (mag > lim);
    v    = eovf ? lim : mag;
    ebcd = '0;
    eblank = '0;
    p = 1;
    for (int i = 0; i < digs; i++) begin
      ebcd[4*i +: 4] = 4'((v / p) % 10);
      if (i > 0 && (v / p) == 0) eblank[i] = 1'b1;
      p = p * 10;
    end
  endtask

  task automatic check_all(input logic [11:0] b);
    logic [63:0] eb, ebl;
    logic        en, eo;
    model(b, 4, 1'b0, eb, en, eo, ebl);
    chk("def_bcd", 64'(bcd_def), eb);
    chk("def_neg", 64'(neg_def), 64'(en));
    chk("def_ovf", 64'(ovf_def), 64'(eo));
    chk("def_blank", 64'(blank_def), ebl);
    prev_def = eb[15:0];
    model(b, 3, 1'b0, eb, en, eo, ebl);
    chk("d3_bcd", 64'(bcd_d3), eb);
    chk("d3_neg", 64'(neg_d3), 64'(en));
    chk("d3_ovf", 64'(ovf_d3), 64'(eo));
    chk("d3_blank", 64'(blank_d3), ebl);
    prev_d3 = eb[15:0];
    model(b, 4, 1'b1, eb, en, eo, ebl);
    chk("sg_bcd", 64'(bcd_sg), eb);
    chk("sg_neg", 64'(neg_sg), 64'(en));
    chk("sg_ovf", 64'(ovf_sg), 64'(eo));
    chk("sg_blank", 64'(blank_sg), ebl);
    prev_sg = eb[15:0];
  endtask

  // Counts negedges until done_tick; meanwhile the displayed results must
  // keep the previous values.
  task automatic wait_done(output int n);
    n = 0;
    held_ok = 1'b1;
    while (!done_def && n < 60) begin
      if (bcd_def !== prev_def || bcd_d3 !== prev_d3[11:0] || bcd_sg !== prev_sg)
        held_ok = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_conv(input logic [11:0] b);
    int n;
    bin   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin   = 12'($urandom);
    wait_done(n);
    chk("latency", 64'(n), 64'd12);
    chk("hold_during_op", 64'(held_ok), 64'd1);
    chk("done_d3", 64'(done_d3), 64'd1);
    chk("done_sg", 64'(done_sg), 64'd1);
    chk("ready_in_done", 64'(ready_def), 64'd0);
    check_all(b);
    $display("conv bin=%03h def=%04h d3=%03h ovf3=%0b sg=%04h neg=%0b",
             b, bcd_def, bcd_d3, ovf_d3, bcd_sg, neg_sg);
    @(negedge clk);
    chk("done_one_cycle", 64'(done_def), 64'd0);
    chk("ready_after_done", 64'(ready_def), 64'd1);
  endtask

  initial begin
    int  n;
    bit  no_done;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    prev_def = '0;
    prev_d3  = '0;
    prev_sg  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready_def & ready_d3 & ready_sg), 64'd1);
    chk("rst_done", 64'(done_def | done_d3 | done_sg), 64'd0);
    chk("rst_bcd", 64'(bcd_def | bcd_sg | 16'(bcd_d3)), 64'd0);
    chk("rst_blank_def", 64'(blank_def), 64'b1110);
    chk("rst_blank_d3", 64'(blank_d3), 64'b110);
    chk("rst_flags", 64'(neg_def | neg_sg | ovf_def | ovf_d3 | ovf_sg), 64'd0);
    $display("reset released");
    rst = 1'b0;
    @(negedge clk);

    do_conv(12'd2047);

    // Back-to-back with start held high; operand changes while busy.
    bin   = 12'd0;
    start = 1'b1;
    @(negedge clk);
    bin = 12'd777;
    wait_done(n);
    chk("b2b_first_latency", 64'(n), 64'd12);
    check_all(12'd0);
    $display("conv bin=000 def=%04h blank=%04b (back-to-back first)", bcd_def, blank_def);
    bin = 12'd4095;
    @(negedge clk);
    wait_done(n);
    chk("b2b_spacing", 64'(n + 1), 64'd14);
    chk("b2b_hold", 64'(held_ok), 64'd1);
    check_all(12'd4095);
    $display("conv bin=fff def=%04h blank=%04b (back-to-back second)", bcd_def, blank_def);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_ready", 64'(ready_def), 64'd1);

    do_conv(12'd1000);
    do_conv(12'd999);
    do_conv(12'hF9C);
    do_conv(12'h800);
    do_conv(12'd2047);
    do_conv(12'd5);

    // Reset in the middle of a conversion.
    bin   = 12'd1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    bin   = 12'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready", 64'(ready_def & ready_d3 & ready_sg), 64'd1);
    chk("abort_done", 64'(done_def | done_d3 | done_sg), 64'd0);
    chk("abort_bcd", 64'(bcd_def | bcd_sg | 16'(bcd_d3)), 64'd0);
    chk("abort_blank_def", 64'(blank_def), 64'b1110);
    chk("abort_blank_d3", 64'(blank_d3), 64'b110);
    chk("abort_flags", 64'(neg_def | neg_sg | ovf_def | ovf_d3 | ovf_sg), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_def = '0;
    prev_d3  = '0;
    prev_sg  = '0;
    no_done = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done_def || done_d3 || done_sg || !ready_def) no_done = 1'b0;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(no_done), 64'd1);
    $display("reset during conversion handled");
    do_conv(12'd9);

    for (int i = 0; i < 30; i++) begin
      do_conv(12'($urandom_range(0, 4095)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
